mem_boot_ctrl: RTL

Parametrised boot/reset sequencer between the pipelined CPU and its data memory. After a start request it owns the data-memory port, sweeps a configurable address range writing a fill word, optionally reads the range back and checks it, then hands the port back to the CPU and issues a one-cycle CPU start pulse. It replaces hand-sequenced `rst_n`/`enable`/`start` stimulus in top-level memory-reset tests and is synthesisable for the real top.

---
 rtl/mem_boot_ctrl_if.sv | 27 ++
 rtl/mem_boot_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_ctrl_if.sv
// Data-memory port between mem_boot_ctrl (master) and the memory / top-level mux (slave).
interface mem_boot_ctrl_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
);
  logic          own;      // 1 = boot controller drives addr/we/dataout
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] dataout;  // write data towards memory
  logic [DW-1:0] datain;   // read data from memory

  modport master (
    output own,
    output addr,
    output we,
    output dataout,
    input  datain
  );

  modport slave (
    input  own,
    input  addr,
    input  we,
    input  dataout,
    output datain
  );
endinterface

// File: rtl/mem_boot_ctrl.sv
// Boot/reset sequencer for the CPU data memory.
// Takes the memory port on start, writes FILL to addresses 0..DEPTH-1, optionally reads the
// range back and checks it, then returns the port to the CPU and pulses cpu_start_o.
// Optional build macro: MEM_BOOT_VERIFY_EN enables the read-back check (VERIFY/FAIL states,
// error_o/err_addr_o live). Without it CLEAR goes straight to LAUNCH.
module mem_boot_ctrl #(
  parameter int unsigned   DW     = 16,
  parameter int unsigned   AW     = 8,
  parameter int unsigned   DEPTH  = 256,
  parameter logic [DW-1:0] FILL   = '0,
  parameter int unsigned   RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable_i,
  input  logic            start_i,
  mem_boot_ctrl_if.master mem,
  output logic            cpu_start_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [AW-1:0]   err_addr_o
);

  // Counter is one bit wider than the address so DEPTH == 2**AW terminates cleanly.
  localparam int unsigned CntW     = AW + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StVerify,
    StLaunch,
    StRun,
    StFail
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            own_q;
  logic            we_q;
  logic [DW-1:0]   dout_q;
  logic            cpu_start_q;
  logic            busy_q;
  logic            done_q;

`ifdef MEM_BOOT_VERIFY_EN
  // Read-return tracking: a valid/address shift pipe RD_LAT deep. With RD_LAT == 0 the
  // returned word belongs to the address issued in the same cycle, so no pipe stage is used.
  localparam int unsigned PipeN  = (RD_LAT == 0) ? 1 : RD_LAT;
  localparam int unsigned RetIdx = (RD_LAT == 0) ? 0 : RD_LAT - 1;
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  logic [PipeN-1:0] pv_q;
  logic [AW-1:0]    pa_q [PipeN];
  logic             error_q;
  logic [AW-1:0]    err_addr_q;
  logic             issue_vld;
  logic             ret_vld;
  logic [AW-1:0]    ret_addr;
  logic             mismatch;
  logic             last_ret;

  // Decode the issue slot and the word returning this cycle.
  always_comb begin
    issue_vld = (state_q == StVerify) && (cnt_q < CntW'(DEPTH));
    ret_vld   = 1'b0;
    ret_addr  = '0;
    if (RD_LAT == 0) begin
      ret_vld  = issue_vld;
      ret_addr = cnt_q[AW-1:0];
    end else begin
      ret_vld  = pv_q[RetIdx];
      ret_addr = pa_q[RetIdx];
    end
    mismatch = ret_vld && (mem.datain != FILL);
    last_ret = ret_vld && (ret_addr == LastAddr);
  end

  // Shift issued addresses down the pipe; holds while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int i = 0; i < int'(PipeN); i++) begin
        pa_q[i] <= '0;
      end
    end else if (enable_i) begin
      for (int i = int'(PipeN) - 1; i > 0; i--) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
      pv_q[0] <= issue_vld;
      pa_q[0] <= cnt_q[AW-1:0];
    end
  end
`else
  // Read data is not needed without the read-back check.
  logic unused_datain;
  assign unused_datain = ^mem.datain;
`endif

  // Sequencer FSM with registered outputs; everything freezes while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      own_q       <= 1'b0;
      we_q        <= 1'b0;
      dout_q      <= '0;
      cpu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEM_BOOT_VERIFY_EN
      error_q     <= 1'b0;
      err_addr_q  <= '0;
`endif
    end else if (enable_i) begin
      unique case (state_q)
        StIdle, StRun, StFail: begin
          if (start_i) begin
            state_q     <= StClear;
            cnt_q       <= '0;
            own_q       <= 1'b1;
            we_q        <= 1'b1;
            dout_q      <= FILL;
            cpu_start_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
`ifdef MEM_BOOT_VERIFY_EN
            error_q     <= 1'b0;
            err_addr_q  <= '0;
`endif
          end
        end

        StClear: begin
          if (cnt_q == LastCnt) begin
            we_q  <= 1'b0;
            cnt_q <= '0;
`ifdef MEM_BOOT_VERIFY_EN
            state_q <= StVerify;
`else
            state_q     <= StLaunch;
            own_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            cpu_start_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef MEM_BOOT_VERIFY_EN
        StVerify: begin
          if (issue_vld) begin
            cnt_q <= cnt_q + 1'b1;
          end
          // Only the first mismatch is recorded.
          if (mismatch && !error_q) begin
            error_q    <= 1'b1;
            err_addr_q <= ret_addr;
          end
          // Decide once the final read has returned; include a mismatch on that last word.
          if (last_ret) begin
            cnt_q  <= '0;
            own_q  <= 1'b0;
            busy_q <= 1'b0;
            if (error_q || mismatch) begin
              state_q <= StFail;
            end else begin
              state_q     <= StLaunch;
              done_q      <= 1'b1;
              cpu_start_q <= 1'b1;
            end
          end
        end
`endif

        StLaunch: begin
          cpu_start_q <= 1'b0;
          state_q     <= StRun;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem.own     = own_q;
  assign mem.addr    = cnt_q[AW-1:0];
  // Gated by enable so a paused sweep cannot repeat the write at the held address.
  assign mem.we      = we_q & enable_i;
  assign mem.dataout = dout_q;

  assign cpu_start_o = cpu_start_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef MEM_BOOT_VERIFY_EN
  assign error_o    = error_q;
  assign err_addr_o = err_addr_q;
`else
  assign error_o    = 1'b0;
  assign err_addr_o = '0;
`endif

endmodule
